calc_disp_mux: RTL and testbench

Parametrised display controller for the calculator datapath. It holds a digit buffer of NUM_DIGITS BCD/code nibbles, written by position or by left-shift entry. It drives static per-digit seven-segment outputs plus a time-multiplexed seg/an pair. It adds leading-zero blanking and a blinking error indication driven by the calculator status.

---
 rtl/calc_disp_pkg.sv | 31 +++
 rtl/calc_disp_mux_seg7_dec.sv | 29 ++
 rtl/calc_disp_mux.sv | 134 +++++++++++++
 tb/tb_calc_disp_mux.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_disp_pkg.sv
// Shared types and constants for the calculator display controller:
// status encoding, special digit codes and seven-segment patterns.
package calc_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_READY = 2'b10,
        ST_ERROR = 2'b11
    } status_e;

    localparam logic [3:0] CODE_BLANK = 4'd10;
    localparam logic [3:0] CODE_MINUS = 4'd11;
    localparam logic [3:0] CODE_E     = 4'd12;

    // Segment order {g,f,e,d,c,b,a}, 1 = lit
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/calc_disp_mux_seg7_dec.sv
// Combinational digit-code to seven-segment decoder; every code without a
// glyph (blank and 13-15) decodes to all segments dark.
module seg7_dec
    import calc_disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (code)
            4'd0:       pattern = SEG_0;
            4'd1:       pattern = SEG_1;
            4'd2:       pattern = SEG_2;
            4'd3:       pattern = SEG_3;
            4'd4:       pattern = SEG_4;
            4'd5:       pattern = SEG_5;
            4'd6:       pattern = SEG_6;
            4'd7:       pattern = SEG_7;
            4'd8:       pattern = SEG_8;
            4'd9:       pattern = SEG_9;
            CODE_MINUS: pattern = SEG_MINUS;
            CODE_E:     pattern = SEG_E;
            default:    pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_disp_mux.sv
// Calculator display controller: digit buffer with positional/shift entry,
// leading-zero blanking, blinking error display and a scanned seg/an output.
module calc_disp_mux
    import calc_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int BLANK_LZ   = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic                       shift_en,
    input  logic                       clr,
    input  logic [3:0]                 dig,
    input  logic [3:0]                 pos,
    input  logic [1:0]                 status,
    output logic [NUM_DIGITS-1:0][6:0] displays,
    output logic [6:0]                 seg,
    output logic [NUM_DIGITS-1:0]      an,
    output logic                       pos_err
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [NUM_DIGITS-1:0][3:0] digit_buf;
    logic [NUM_DIGITS-1:0][3:0] eff_code;
    logic [NUM_DIGITS-1:0][6:0] dec_pat;
    logic                       pos_ok;
    logic                       err_mode;
    logic                       nz_above;

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic [SCAN_W-1:0]  scan_cnt;
    logic [IDX_W-1:0]   scan_idx;
    logic [IDX_W-1:0]   idx_sel;
    logic               scan_wrap;

    assign pos_ok   = ({1'b0, pos} < 5'(NUM_DIGITS));
    assign err_mode = (status == ST_ERROR);

    // Buffer update: clr beats shift_en beats wr_en; masked writes never flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            digit_buf <= '0;
            pos_err   <= 1'b0;
        end else begin
            pos_err <= 1'b0;
            if (clr) begin
                digit_buf <= '0;
            end else if (shift_en) begin
                digit_buf <= {digit_buf[NUM_DIGITS-2:0], dig};
            end else if (wr_en) begin
                if (pos_ok) begin
                    digit_buf[pos[IDX_W-1:0]] <= dig;
                end else begin
                    pos_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    // Walk from the top digit down so nz_above tracks "this or any higher is non-zero"
    always_comb begin
        nz_above = 1'b0;
        eff_code = digit_buf;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz_above = nz_above | (digit_buf[i] != 4'd0);
            if (BLANK_LZ != 0 && i != 0 && !nz_above) begin
                eff_code[i] = CODE_BLANK;
            end
            if (err_mode) begin
                eff_code[i] = (i == 0 && !blink_phase) ? CODE_E : CODE_BLANK;
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_dec u_dec (
            .code    (eff_code[g]),
            .pattern (dec_pat[g])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                displays[i] <= (i == 0 || BLANK_LZ == 0) ? SEG_0 : SEG_BLANK;
            end
        end else begin
            displays <= dec_pat;
        end
    end

    assign scan_wrap = (scan_cnt == SCAN_LAST);
    assign idx_sel   = !scan_wrap ? scan_idx :
                       (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);

    // an and seg load from the same index on the same edge so they never skew
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            an       <= NUM_DIGITS'(1);
            seg      <= SEG_0;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
            scan_idx <= idx_sel;
            an       <= NUM_DIGITS'(1) << idx_sel;
            seg      <= displays[idx_sel];
        end
    end

endmodule

// File: tb/tb_calc_disp_mux.sv
// Randomized scoreboard bench for calc_disp_mux with leading-zero blanking
// on and off, checked against a cycle-count based reference model.
module tb_calc_disp_mux;

    localparam int ND = 4;
    localparam int SD = 2;
    localparam int BD = 4;

    localparam logic [ND-1:0][6:0] RST_LZ = {7'h00, 7'h00, 7'h00, 7'h3F};
    localparam logic [ND-1:0][6:0] RST_NZ = {7'h3F, 7'h3F, 7'h3F, 7'h3F};

    logic clock = 1'b0;
    logic reset;
    logic wr_en, shift_en, clr;
    logic [3:0] dig, pos;
    logic [1:0] status;

    logic [ND-1:0][6:0] disp_l, disp_n;
    logic [6:0]         seg_l, seg_n;
    logic [ND-1:0]      an_l, an_n;
    logic               pe_l, pe_n;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    calc_disp_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD), .BLANK_LZ(1)) dut_lz (
        .clock(clock), .reset(reset), .wr_en(wr_en), .shift_en(shift_en), .clr(clr),
        .dig(dig), .pos(pos), .status(status),
        .displays(disp_l), .seg(seg_l), .an(an_l), .pos_err(pe_l)
    );

    calc_disp_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD), .BLANK_LZ(0)) dut_nz (
        .clock(clock), .reset(reset), .wr_en(wr_en), .shift_en(shift_en), .clr(clr),
        .dig(dig), .pos(pos), .status(status),
        .displays(disp_n), .seg(seg_n), .an(an_n), .pos_err(pe_n)
    );

    typedef struct {
        logic [ND-1:0][6:0] dl;
        logic [ND-1:0][6:0] dn;
        logic [6:0]         sl;
        logic [6:0]         sn;
        logic [ND-1:0]      an;
        logic               pe;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] pat(input logic [3:0] c);
        case (c)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;  4'd11: return 7'h40; 4'd12: return 7'h79;
            default: return 7'h00;
        endcase
    endfunction

    // What the display should show for a given buffer, blanking mode, status and blink phase
    function automatic logic [ND-1:0][6:0] show(input logic [ND-1:0][3:0] b, input bit lz,
                                               input logic [1:0] st, input bit ph);
        logic [ND-1:0][6:0] r;
        int top;
        logic [3:0] c;
        top = 0;
        for (int i = 0; i < ND; i++) if (b[i] != 4'd0) top = i;
        for (int i = 0; i < ND; i++) begin
            if (st == 2'b11)       c = (ph || i != 0) ? 4'd10 : 4'd12;
            else if (lz && i > top) c = 4'd10;
            else                    c = b[i];
            r[i] = pat(c);
        end
        return r;
    endfunction

    // Reference model: state is a plain buffer plus a count of edges since reset
    int                 n;
    logic [ND-1:0][3:0] mb;
    logic [ND-1:0][6:0] prev_l, prev_n;

    always @(posedge clock or posedge reset) begin
        exp_t e;
        int   idx;
        bit   ph;
        if (reset) begin
            n = 0;
            mb = '0;
            prev_l = RST_LZ;
            prev_n = RST_NZ;
            sb.delete();
        end else begin
            ph = ((n / BD) % 2) == 1;
            n++;
            idx = (n / SD) % ND;
            e.dl = show(mb, 1'b1, status, ph);
            e.dn = show(mb, 1'b0, status, ph);
            e.sl = prev_l[idx];
            e.sn = prev_n[idx];
            e.an = ND'(1) << idx;
            e.pe = wr_en && !clr && !shift_en && (pos >= ND);
            if (clr) mb = '0;
            else if (shift_en) begin
                for (int i = ND - 1; i > 0; i--) mb[i] = mb[i-1];
                mb[0] = dig;
            end else if (wr_en && pos < ND) mb[pos] = dig;
            prev_l = e.dl;
            prev_n = e.dn;
            sb.push_back(e);
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (!reset && sb.size() > 0) begin
            e = sb.pop_front();
            chk("displays_lz", 32'(disp_l), 32'(e.dl));
            chk("displays_nz", 32'(disp_n), 32'(e.dn));
            chk("seg_lz", 32'(seg_l), 32'(e.sl));
            chk("seg_nz", 32'(seg_n), 32'(e.sn));
            chk("an_lz", 32'(an_l), 32'(e.an));
            chk("an_nz", 32'(an_n), 32'(e.an));
            chk("pos_err_lz", 32'(pe_l), 32'(e.pe));
            chk("pos_err_nz", 32'(pe_n), 32'(e.pe));
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_displays_lz"}, 32'(disp_l), 32'(RST_LZ));
        chk({tag, "_displays_nz"}, 32'(disp_n), 32'(RST_NZ));
        chk({tag, "_an"}, 32'(an_l), 32'h1);
        chk({tag, "_seg_lz"}, 32'(seg_l), 32'h3F);
        chk({tag, "_seg_nz"}, 32'(seg_n), 32'h3F);
        chk({tag, "_pos_err"}, 32'(pe_l | pe_n), 32'h0);
    endtask

    task automatic cyc(input bit w, input bit s, input bit c, input logic [3:0] d,
                       input logic [3:0] p, input logic [1:0] st);
        @(negedge clock);
        wr_en = w; shift_en = s; clr = c; dig = d; pos = p; status = st;
    endtask

    task automatic rand_cycles(input int cnt);
        logic [1:0] st;
        st = status;
        for (int k = 0; k < cnt; k++) begin
            if ($urandom_range(0, 15) == 0) st = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 5)), st);
        end
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 0; shift_en = 0; clr = 0; dig = 0; pos = 0; status = 2'b00;
        repeat (2) @(negedge clock);
        check_reset("rst_init");
        reset = 1'b0;

        cyc(0, 1, 0, 4'd1, 0, 2'b10);
        cyc(0, 1, 0, 4'd2, 0, 2'b10);
        cyc(0, 1, 0, 4'd3, 0, 2'b10);
        cyc(0, 0, 0, 0, 0, 2'b10);
        cyc(1, 0, 0, 4'd0, 4'd2, 2'b10);
        cyc(0, 0, 0, 0, 0, 2'b10);
        cyc(1, 0, 0, 4'd9, 4'd5, 2'b10);
        cyc(0, 0, 0, 0, 0, 2'b10);
        cyc(0, 0, 0, 0, 0, 2'b10);
        cyc(1, 0, 1, 4'd7, 4'd6, 2'b10);
        cyc(1, 1, 0, 4'd11, 4'd4, 2'b10);
        cyc(0, 1, 0, 4'd5, 0, 2'b10);
        for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0, 0, 2'b10);
        for (int k = 0; k < 20; k++) cyc(0, 0, 0, 0, 0, 2'b11);
        cyc(0, 0, 1, 0, 0, 2'b10);
        cyc(0, 1, 0, 4'd8, 0, 2'b11);
        for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 0, 2'b10);

        rand_cycles(600);

        cyc(0, 1, 0, 4'd7, 0, 2'b10);
        cyc(0, 0, 0, 0, 0, 2'b10);
        @(posedge clock);
        #3 reset = 1'b1;
        #1 check_reset("rst_async");
        @(negedge clock);
        reset = 1'b0;

        rand_cycles(200);
        cyc(0, 0, 0, 0, 0, 2'b00);
        repeat (2) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
